// File: rtl/spi_sequenciador.sv
// spi_sequenciador
//   Upstream sequencer for spi_master. Host bytes are buffered in a TX FIFO; one
//   multi-byte SPI transaction runs per chip-select window. Bytes go to spi_master
//   one at a time over tx_dado/tx_valido/tx_pronto. Only one byte is ever in flight.
//   Every byte spi_master returns is forwarded to the host on rd_dado/rd_valido.
//
// Parameters
//   PROFUNDIDADE_FIFO : TX FIFO depth in bytes (power of 2, >= 2)
//   CICLOS_GUARDA     : CS setup/hold guard length in clk cycles (guard build only)
//
// Configuration
//   SPI_CS_GUARDA_EN  : when defined, adds GUARDA_INI after cs_n falls and
//                       GUARDA_FIM after the last received byte. Each lasts
//                       CICLOS_GUARDA cycles, and cs_n stays low through both.
//
// Ports
//   clk, rst_n               : clock, async active-low reset (aborts a transfer)
//   wr_dado/wr_valido        : host enqueue; wr_pronto = FIFO not full
//   inicio/num_bytes         : start pulse and byte count (1..255, 0 is ignored)
//   ocupado, fim             : transaction busy flag, 1-cycle completion pulse
//   rd_dado/rd_valido        : received byte and 1-cycle strobe
//   cs_n                     : SPI chip select, active low
//   tx_dado/tx_valido/tx_pronto : byte handshake to spi_master
//   rx_dado/rx_valido        : received byte from spi_master
module spi_sequenciador #(
  parameter int PROFUNDIDADE_FIFO = 8,
  parameter int CICLOS_GUARDA     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_dado,
  input  logic       wr_valido,
  output logic       wr_pronto,
  input  logic       inicio,
  input  logic [7:0] num_bytes,
  output logic       ocupado,
  output logic       fim,
  output logic [7:0] rd_dado,
  output logic       rd_valido,
  output logic       cs_n,
  output logic [7:0] tx_dado,
  output logic       tx_valido,
  input  logic       tx_pronto,
  input  logic [7:0] rx_dado,
  input  logic       rx_valido
);
  localparam int PW = $clog2(PROFUNDIDADE_FIFO);

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]    mem [PROFUNDIDADE_FIFO];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   ocup;
  logic          push, pop, vazio;

  assign wr_pronto = (ocup != (PW+1)'(PROFUNDIDADE_FIFO));
  assign vazio     = (ocup == '0);
  assign push      = wr_valido && wr_pronto;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_dado;

  // Pointers wrap naturally because the depth is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocup   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      ocup <= ocup + 1'b1;
      else if (pop && !push) ocup <= ocup - 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM
  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    ENVIA      = 3'd1,
    AGUARDA_RX = 3'd2,
    FIM        = 3'd3
`ifdef SPI_CS_GUARDA_EN
    ,
    GUARDA_INI = 3'd4,
    GUARDA_FIM = 3'd5
`endif
  } estado_t;

  estado_t    estado, estado_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       cs_n_nxt, ocupado_nxt, fim_nxt, rd_valido_nxt, tx_valido_nxt;
  logic [7:0] rd_dado_nxt, tx_dado_nxt;

`ifdef SPI_CS_GUARDA_EN
  localparam int GW = (CICLOS_GUARDA > 1) ? $clog2(CICLOS_GUARDA) : 1;
  logic [GW-1:0] guarda, guarda_nxt;
  logic          guarda_ult;
  // Last cycle of the guard window: the counter runs 0..CICLOS_GUARDA-1.
  assign guarda_ult = (guarda == GW'(CICLOS_GUARDA - 1));
`endif

  // All outputs are registered: next values are computed here. Because tx_valido
  // is registered, the first byte appears at least one cycle after cs_n falls.
  always_comb begin
    estado_nxt    = estado;
    cnt_nxt       = cnt;
    cs_n_nxt      = cs_n;
    ocupado_nxt   = ocupado;
    fim_nxt       = 1'b0;
    rd_valido_nxt = 1'b0;
    rd_dado_nxt   = rd_dado;
    tx_valido_nxt = 1'b0;
    tx_dado_nxt   = tx_dado;
    pop           = 1'b0;
`ifdef SPI_CS_GUARDA_EN
    guarda_nxt    = guarda;
`endif
    unique case (estado)
      OCIOSO: begin
        if (inicio && num_bytes != 8'd0) begin
          cnt_nxt     = num_bytes;
          cs_n_nxt    = 1'b0;
          ocupado_nxt = 1'b1;
`ifdef SPI_CS_GUARDA_EN
          guarda_nxt  = '0;
          estado_nxt  = GUARDA_INI;
`else
          estado_nxt  = ENVIA;
`endif
        end
      end
`ifdef SPI_CS_GUARDA_EN
      GUARDA_INI: begin
        if (guarda_ult) estado_nxt = ENVIA;
        else            guarda_nxt = guarda + 1'b1;
      end
`endif
      // An empty FIFO simply stalls here with cs_n low until the host catches up.
      ENVIA: begin
        if (!vazio && tx_pronto) begin
          tx_valido_nxt = 1'b1;
          tx_dado_nxt   = mem[rd_ptr];
          pop           = 1'b1;
          estado_nxt    = AGUARDA_RX;
        end
      end
      AGUARDA_RX: begin
        if (rx_valido) begin
          rd_dado_nxt   = rx_dado;
          rd_valido_nxt = 1'b1;
          cnt_nxt       = cnt - 8'd1;
          if (cnt == 8'd1) begin
`ifdef SPI_CS_GUARDA_EN
            guarda_nxt = '0;
            estado_nxt = GUARDA_FIM;
`else
            estado_nxt = FIM;
`endif
          end else begin
            estado_nxt = ENVIA;
          end
        end
      end
`ifdef SPI_CS_GUARDA_EN
      GUARDA_FIM: begin
        if (guarda_ult) estado_nxt = FIM;
        else            guarda_nxt = guarda + 1'b1;
      end
`endif
      FIM: begin
        cs_n_nxt    = 1'b1;
        ocupado_nxt = 1'b0;
        fim_nxt     = 1'b1;
        estado_nxt  = OCIOSO;
      end
      default: estado_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      cnt       <= '0;
      cs_n      <= 1'b1;
      ocupado   <= 1'b0;
      fim       <= 1'b0;
      rd_valido <= 1'b0;
      rd_dado   <= '0;
      tx_valido <= 1'b0;
      tx_dado   <= '0;
`ifdef SPI_CS_GUARDA_EN
      guarda    <= '0;
`endif
    end else begin
      estado    <= estado_nxt;
      cnt       <= cnt_nxt;
      cs_n      <= cs_n_nxt;
      ocupado   <= ocupado_nxt;
      fim       <= fim_nxt;
      rd_valido <= rd_valido_nxt;
      rd_dado   <= rd_dado_nxt;
      tx_valido <= tx_valido_nxt;
      tx_dado   <= tx_dado_nxt;
`ifdef SPI_CS_GUARDA_EN
      guarda    <= guarda_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_spi_sequenciador.sv
// Bench for spi_sequenciador. Acts as host and as a spi_master stand-in.
// Expected TX order comes from a queue model of the FIFO; expected RX bytes come
// from what the stand-in returned. The guard length follows SPI_CS_GUARDA_EN.
module tb_spi_sequenciador;
  localparam int DEPTH  = 8;
`ifdef SPI_CS_GUARDA_EN
  localparam int G      = 4;
`else
  localparam int G      = 0;
`endif
  localparam int BUDGET = 600;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] wr_dado = '0;
  logic       wr_valido = 1'b0, wr_pronto;
  logic       inicio = 1'b0;
  logic [7:0] num_bytes = '0;
  logic       ocupado, fim, rd_valido, cs_n, tx_valido;
  logic [7:0] rd_dado, tx_dado;
  logic       tx_pronto = 1'b0;
  logic [7:0] rx_dado = '0;
  logic       rx_valido = 1'b0;

  spi_sequenciador #(.PROFUNDIDADE_FIFO(DEPTH), .CICLOS_GUARDA(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_dado(wr_dado), .wr_valido(wr_valido), .wr_pronto(wr_pronto),
    .inicio(inicio), .num_bytes(num_bytes), .ocupado(ocupado), .fim(fim),
    .rd_dado(rd_dado), .rd_valido(rd_valido), .cs_n(cs_n),
    .tx_dado(tx_dado), .tx_valido(tx_valido), .tx_pronto(tx_pronto),
    .rx_dado(rx_dado), .rx_valido(rx_valido)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  logic [7:0] mq[$];                       // FIFO model
  logic [7:0] exp_sent_q[$], sent_q[$], rxgen_q[$], rd_q[$], miso_q[$];
  int         rx_wait = -1;
  logic [7:0] rx_byte = '0;
  bit         hold = 1'b0, noise = 1'b0;
  int         auto_left = 0;
  int         inicio_cyc, csfall_cyc, csrise_cyc, first_txv_cyc, last_rdv_cyc, fim_cyc;
  int         cs_falls, cs_rises, fim_cnt, proto_err;
  logic       cs_prev = 1'b1;

  function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: apply pending host inputs, advance, observe, run the stand-in.
  task automatic step();
    if (!wr_valido && auto_left > 0 && mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
      wr_valido = 1'b1; wr_dado = 8'($urandom); auto_left--;
    end
    if (wr_valido && rst_n && mq.size() < DEPTH) mq.push_back(wr_dado);
    if (inicio) inicio_cyc = cyc;
    tx_pronto = (rx_wait < 0) && !hold && !(noise && $urandom_range(0, 3) == 0);
    @(posedge clk); #1;
    cyc++;
    wr_valido = 1'b0; inicio = 1'b0; rx_valido = 1'b0;
    if (cs_prev && !cs_n) begin cs_falls++; csfall_cyc = cyc; end
    if (!cs_prev && cs_n) begin cs_rises++; csrise_cyc = cyc; end
    cs_prev = cs_n;
    if (fim) begin fim_cnt++; fim_cyc = cyc; end
    if (rd_valido) begin rd_q.push_back(rd_dado); last_rdv_cyc = cyc; end
    if (rx_wait == 0) begin
      rx_valido = 1'b1; rx_dado = rx_byte; rxgen_q.push_back(rx_byte); rx_wait = -1;
    end else if (rx_wait > 0) rx_wait--;
    if (tx_valido) begin
      if (cs_n || rx_wait >= 0 || rx_valido) proto_err++;
      sent_q.push_back(tx_dado);
      if (first_txv_cyc < 0) first_txv_cyc = cyc;
      if (mq.size() > 0) exp_sent_q.push_back(mq.pop_front()); else proto_err++;
      rx_byte = (miso_q.size() > 0) ? miso_q.pop_front() : 8'($urandom);
      rx_wait = $urandom_range(0, 3);
    end else if (noise && rx_wait < 0 && !rx_valido && $urandom_range(0, 3) == 0) begin
      rx_valido = 1'b1; rx_dado = 8'($urandom);   // stray strobe, must be ignored
    end
  endtask

  task automatic clear_rec();
    sent_q.delete(); exp_sent_q.delete(); rxgen_q.delete(); rd_q.delete();
    cs_falls = 0; cs_rises = 0; fim_cnt = 0; proto_err = 0;
    inicio_cyc = -1; csfall_cyc = -1; csrise_cyc = -1;
    first_txv_cyc = -1; last_rdv_cyc = -1; fim_cyc = -1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valido = 1'b1; wr_dado = b; step();
  endtask

  task automatic start(input logic [7:0] n);
    inicio = 1'b1; num_bytes = n; step();
  endtask

  task automatic run_to_fim(output bit ok);
    int k = 0;
    while (fim_cnt == 0 && k < BUDGET) begin step(); k++; end
    ok = (fim_cnt > 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (cs_n !== 1'b1)      begin bad++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    total++; if (ocupado !== 1'b0)   begin bad++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
    total++; if ({fim, rd_valido, tx_valido} !== 3'b000)
      begin bad++; $display("FAIL reset_pulses got=%b exp=000", {fim, rd_valido, tx_valido}); end
    total++; if ({tx_dado, rd_dado} !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", {tx_dado, rd_dado}); end
    total++; if (wr_pronto !== 1'b1) begin bad++; $display("FAIL reset_wr_pronto got=%b exp=1", wr_pronto); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] e[$];
    clear_rec();
    miso_q.push_back(8'h3C);
    write_byte(8'hA5);
    start(8'd1);
    run_to_fim(ok);
    repeat (2) step();
    total++; if (!ok) begin bad++; $display("FAIL single_fim_timeout got=none exp=fim"); end
    e = '{8'hA5};
    total++; if (!q_eq(sent_q, e)) begin bad++; $display("FAIL single_tx got=%p exp=%p", sent_q, e); end
    e = '{8'h3C};
    total++; if (!q_eq(rd_q, e)) begin bad++; $display("FAIL single_rx got=%p exp=%p", rd_q, e); end
    total++; if (fim_cnt != 1) begin bad++; $display("FAIL single_fim_count got=%0d exp=1", fim_cnt); end
    total++; if (cs_falls != 1 || cs_rises != 1 || csrise_cyc != fim_cyc)
      begin bad++; $display("FAIL single_cs_window got=falls%0d/rises%0d/rise@%0d exp=1/1/%0d", cs_falls, cs_rises, csrise_cyc, fim_cyc); end
    total++; if (csfall_cyc != inicio_cyc + 1)
      begin bad++; $display("FAIL single_cs_latency got=%0d exp=%0d", csfall_cyc - inicio_cyc, 1); end
    total++; if (first_txv_cyc - csfall_cyc != 1 + G)
      begin bad++; $display("FAIL single_setup_guard got=%0d exp=%0d", first_txv_cyc - csfall_cyc, 1 + G); end
    total++; if (fim_cyc - last_rdv_cyc != 1 + G)
      begin bad++; $display("FAIL single_hold_guard got=%0d exp=%0d", fim_cyc - last_rdv_cyc, 1 + G); end
    total++; if (proto_err != 0 || ocupado !== 1'b0)
      begin bad++; $display("FAIL single_protocol got=err%0d/ocupado%b exp=0/0", proto_err, ocupado); end
  endtask

  task automatic test_burst();
    bit ok;
    logic [7:0] e[$];
    clear_rec();
    for (int i = 1; i <= 4; i++) write_byte(8'(i));
    start(8'd4);
    run_to_fim(ok);
    repeat (3) step();
    e = '{8'h01, 8'h02, 8'h03, 8'h04};
    total++; if (!ok || !q_eq(sent_q, e)) begin bad++; $display("FAIL burst_tx got=%p exp=%p", sent_q, e); end
    total++; if (!q_eq(rd_q, rxgen_q) || rd_q.size() != 4)
      begin bad++; $display("FAIL burst_rx got=%p exp=%p", rd_q, rxgen_q); end
    total++; if (fim_cnt != 1 || cs_falls != 1 || cs_rises != 1)
      begin bad++; $display("FAIL burst_window got=fim%0d/falls%0d/rises%0d exp=1/1/1", fim_cnt, cs_falls, cs_rises); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int k;
    logic [7:0] e[$];
    clear_rec();
    hold = 1'b1;
    for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
    total++; if (wr_pronto !== 1'b0) begin bad++; $display("FAIL full_wr_pronto got=%b exp=0", wr_pronto); end
    write_byte(8'hEE);                     // dropped
    total++; if (wr_pronto !== 1'b0) begin bad++; $display("FAIL full_after_drop got=%b exp=0", wr_pronto); end
    start(8'd2);
    repeat (G + 3) step();
    hold = 1'b0; step(); hold = 1'b1;      // one pop
    total++; if (wr_pronto !== 1'b1) begin bad++; $display("FAIL full_after_pop got=%b exp=1", wr_pronto); end
    k = 0;
    while (rd_q.size() == 0 && k < BUDGET) begin step(); k++; end
    wr_valido = 1'b1; wr_dado = 8'h99; hold = 1'b0;
    step();                                // write and pop on the same edge
    hold = 1'b1;
    total++; if (sent_q.size() != 2 || wr_pronto !== 1'b1)
      begin bad++; $display("FAIL full_wr_pop got=pops%0d/pronto%b exp=2/1", sent_q.size(), wr_pronto); end
    write_byte(8'h77);
    total++; if (wr_pronto !== 1'b0) begin bad++; $display("FAIL full_occ7 got=%b exp=0", wr_pronto); end
    hold = 1'b0;
    run_to_fim(ok);
    step();
    e = '{8'h10, 8'h11};
    total++; if (!ok || !q_eq(sent_q, e)) begin bad++; $display("FAIL full_first_tx got=%p exp=%p", sent_q, e); end
    clear_rec();
    start(8'd8);
    run_to_fim(ok);
    step();
    e = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99, 8'h77};
    total++; if (!ok || !q_eq(sent_q, e)) begin bad++; $display("FAIL full_drain_tx got=%p exp=%p", sent_q, e); end
  endtask

  task automatic test_underrun();
    bit ok;
    int k;
    logic [7:0] e[$];
    clear_rec();
    write_byte(8'h31);
    start(8'd3);
    k = 0;
    while (rd_q.size() == 0 && k < BUDGET) begin step(); k++; end
    repeat (10) step();
    total++; if (sent_q.size() != 1 || cs_n !== 1'b0 || ocupado !== 1'b1)
      begin bad++; $display("FAIL underrun_stall got=tx%0d/cs%b/oc%b exp=1/0/1", sent_q.size(), cs_n, ocupado); end
    write_byte(8'h32);
    repeat (2) step();
    write_byte(8'h33);
    run_to_fim(ok);
    step();
    e = '{8'h31, 8'h32, 8'h33};
    total++; if (!ok || !q_eq(sent_q, e)) begin bad++; $display("FAIL underrun_tx got=%p exp=%p", sent_q, e); end
    total++; if (rd_q.size() != 3 || fim_cnt != 1 || cs_falls != 1)
      begin bad++; $display("FAIL underrun_done got=rx%0d/fim%0d/falls%0d exp=3/1/1", rd_q.size(), fim_cnt, cs_falls); end
  endtask

  task automatic test_ignore();
    bit ok;
    logic [7:0] e[$];
    for (int i = 0; i < 4; i++) write_byte(8'h41 + 8'(i));
    clear_rec();
    start(8'd0);
    repeat (5) step();
    total++; if (cs_n !== 1'b1 || ocupado !== 1'b0 || cs_falls != 0)
      begin bad++; $display("FAIL ignore_zero got=cs%b/oc%b exp=1/0", cs_n, ocupado); end
    start(8'd2);
    repeat (3) step();
    start(8'd5);                           // while busy
    run_to_fim(ok);
    repeat (8) step();
    e = '{8'h41, 8'h42};
    total++; if (!ok || !q_eq(sent_q, e) || fim_cnt != 1)
      begin bad++; $display("FAIL ignore_busy_tx got=%p exp=%p", sent_q, e); end
    total++; if (cs_falls != 1 || cs_n !== 1'b1 || ocupado !== 1'b0)
      begin bad++; $display("FAIL ignore_busy_idle got=falls%0d/cs%b/oc%b exp=1/1/0", cs_falls, cs_n, ocupado); end
    clear_rec();
    start(8'd2);
    run_to_fim(ok);
    step();
    e = '{8'h43, 8'h44};
    total++; if (!ok || !q_eq(sent_q, e)) begin bad++; $display("FAIL ignore_drain got=%p exp=%p", sent_q, e); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    logic [7:0] e[$];
    clear_rec();
    for (int i = 0; i < 3; i++) write_byte(8'h51 + 8'(i));
    start(8'd3);
    k = 0;
    while (sent_q.size() < 2 && k < BUDGET) begin step(); k++; end
    rst_n = 1'b0;
    #1;
    total++; if (cs_n !== 1'b1 || ocupado !== 1'b0 || wr_pronto !== 1'b1 || tx_valido !== 1'b0)
      begin bad++; $display("FAIL rstmid_async got=cs%b/oc%b/pr%b/tv%b exp=1/0/1/0", cs_n, ocupado, wr_pronto, tx_valido); end
    mq.delete(); rx_wait = -1; rx_valido = 1'b0; hold = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    total++; if (fim_cnt != 0 || cs_n !== 1'b1)
      begin bad++; $display("FAIL rstmid_no_fim got=fim%0d/cs%b exp=0/1", fim_cnt, cs_n); end
    clear_rec();
    write_byte(8'h5A);
    start(8'd1);
    run_to_fim(ok);
    step();
    e = '{8'h5A};
    total++; if (!ok || !q_eq(sent_q, e)) begin bad++; $display("FAIL rstmid_flushed got=%p exp=%p", sent_q, e); end
  endtask

  task automatic test_random();
    bit ok;
    int n, pre;
    for (int t = 0; t < 6; t++) begin
      clear_rec();
      n   = $urandom_range(1, 12);
      pre = $urandom_range(1, (n < DEPTH) ? n : DEPTH);
      for (int i = 0; i < pre; i++) write_byte(8'($urandom));
      auto_left = n - pre;
      noise = 1'b1;
      start(8'(n));
      run_to_fim(ok);
      noise = 1'b0; auto_left = 0;
      repeat (2) step();
      total++; if (!ok || sent_q.size() != n || !q_eq(sent_q, exp_sent_q))
        begin bad++; $display("FAIL random_tx t=%0d got=%p exp=%p", t, sent_q, exp_sent_q); end
      total++; if (rd_q.size() != n || !q_eq(rd_q, rxgen_q))
        begin bad++; $display("FAIL random_rx t=%0d got=%p exp=%p", t, rd_q, rxgen_q); end
      total++; if (fim_cnt != 1 || cs_falls != 1 || fim_cyc - last_rdv_cyc != 1 + G || proto_err != 0)
        begin bad++; $display("FAIL random_frame t=%0d got=fim%0d/falls%0d/gap%0d/err%0d exp=1/1/%0d/0",
                              t, fim_cnt, cs_falls, fim_cyc - last_rdv_cyc, proto_err, 1 + G); end
    end
  endtask

  initial begin
    clear_rec();
    test_reset();
    test_single();
    test_burst();
    test_fifo_full();
    test_underrun();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
